// File: rtl/q_divider_if.sv
// Start/done handshake bundle for the sequential Q-format divider.
// master drives the request side, slave (the divider) drives the result side.
interface q_divider_if #(
   parameter int N = 16
) ();
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] q;
   logic         overflow;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, q, overflow, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, q, overflow, div_by_zero
   );
endinterface

// File: rtl/q_divider_seq.sv
// Sequential signed Q-format divider: non-restoring, one quotient bit per cycle, 2N+2 cycle latency.
// Optional macro Q_DIVIDER_SAT_EN saturates the result on overflow; otherwise an overflowing result reads as zero.
module q_divider_seq #(
   parameter int N      = 16,
   parameter int SF_W   = 3,
   parameter int OUT_SF = 3
) (
   input  logic       clk,
   input  logic       reset,
   q_divider_if.slave io
);
   localparam int MW = N - SF_W;
   localparam int W2 = 2 * N;
   localparam int CW = $clog2(W2 + 1);
   localparam logic [W2-1:0]   POS_LIM  = W2'((64'd1 << (MW - 1)) - 64'd1);
   localparam logic [W2-1:0]   NEG_LIM  = W2'(64'd1 << (MW - 1));
   localparam logic [SF_W-1:0] OUT_SF_F = SF_W'(OUT_SF);
   localparam logic [SF_W:0]   OUT_SF_X = (SF_W + 1)'(OUT_SF);

   generate
      if (MW + OUT_SF + (1 << SF_W) - 1 > W2) begin : g_bad_width
         $error("q_divider_seq: aligned numerator does not fit in 2N bits");
      end
      if (OUT_SF >= (1 << SF_W)) begin : g_bad_out_sf
         $error("q_divider_seq: OUT_SF does not fit in the scale field");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ALIGN, ITER, FINISH} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic            sign_q, sign_d;
   logic [W2-1:0]   num_q, num_d, den_q, den_d;
   logic [W2:0]     rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    q_q, q_d;
   logic            ovf_q, ovf_d;
   logic            dbz_q, dbz_d;
   logic            done_q, done_d;

   logic [MW-1:0]   m1, m2;
   logic [SF_W-1:0] s1, s2;
   logic [MW:0]     abs1, abs2;
   logic [SF_W:0]   nsh, dsh;
   logic [W2:0]     rem_sh, rem_nx;
   logic [W2-1:0]   qmag;
   logic            res_ovf;
   logic [MW-1:0]   res_mant;
   logic [N-1:0]    sat_word;

   // Operand decode and alignment shifts; abs is one bit wider so -2^(MW-1) survives.
   always_comb begin
      m1   = a_q[N-1:SF_W];
      s1   = a_q[SF_W-1:0];
      m2   = b_q[N-1:SF_W];
      s2   = b_q[SF_W-1:0];
      abs1 = m1[MW-1] ? -{1'b1, m1} : {1'b0, m1};
      abs2 = m2[MW-1] ? -{1'b1, m2} : {1'b0, m2};
      nsh  = (s2 > s1) ? OUT_SF_X + ({1'b0, s2} - {1'b0, s1}) : OUT_SF_X;
      dsh  = (s1 > s2) ? ({1'b0, s1} - {1'b0, s2}) : '0;
   end

   // One non-restoring step; qmag is the quotient after this step's bit lands.
   always_comb begin
      rem_sh   = {rem_q[W2-1:0], num_q[W2-1]};
      rem_nx   = rem_q[W2] ? rem_sh + {1'b0, den_q} : rem_sh - {1'b0, den_q};
      qmag     = {num_q[W2-2:0], ~rem_nx[W2]};
      res_ovf  = sign_q ? (qmag > NEG_LIM) : (qmag > POS_LIM);
      res_mant = sign_q ? -qmag[MW-1:0] : qmag[MW-1:0];
`ifdef Q_DIVIDER_SAT_EN
      sat_word = sign_q ? {1'b1, {(MW-1){1'b0}}, OUT_SF_F}
                        : {1'b0, {(MW-1){1'b1}}, OUT_SF_F};
`else
      sat_word = '0;
`endif
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      num_d   = num_q;
      den_d   = den_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (io.start) begin
               a_d     = io.dividend;
               b_d     = io.divisor;
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            sign_d = m1[MW-1] ^ m2[MW-1];
            if (m2 == '0) begin
               q_d     = '0;
               ovf_d   = 1'b0;
               dbz_d   = 1'b1;
               done_d  = 1'b1;
               state_d = FINISH;
            end else begin
               num_d   = W2'(abs1) << nsh;
               den_d   = W2'(abs2) << dsh;
               rem_d   = '0;
               cnt_d   = CW'(W2);
               state_d = ITER;
            end
         end
         ITER: begin
            num_d = qmag;
            rem_d = rem_nx;
            cnt_d = cnt_q - CW'(1);
            // Result is registered on the last step so it is valid for the whole done cycle.
            if (cnt_q == CW'(1)) begin
               ovf_d   = res_ovf;
               dbz_d   = 1'b0;
               q_d     = res_ovf ? sat_word : {res_mant, OUT_SF_F};
               done_d  = 1'b1;
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         num_q   <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         num_q   <= num_d;
         den_q   <= den_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign io.busy        = (state_q == ALIGN) || (state_q == ITER);
   assign io.done        = done_q;
   assign io.q           = q_q;
   assign io.overflow    = ovf_q;
   assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_q_divider_seq.sv
// Scoreboard bench for q_divider_seq (N=16, SF_W=3, OUT_SF=3): directed vectors, monitor pops on done.
// Overflow expectations follow Q_DIVIDER_SAT_EN when it is defined for the build.
module tb_q_divider_seq;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   q_divider_if #(.N(16)) io ();

   q_divider_seq #(.N(16), .SF_W(3), .OUT_SF(3)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io.slave)
   );

`ifdef Q_DIVIDER_SAT_EN
   localparam logic [15:0] SAT_P = 16'h7FFB;
   localparam logic [15:0] SAT_N = 16'h8003;
`else
   localparam logic [15:0] SAT_P = 16'h0000;
   localparam logic [15:0] SAT_N = 16'h0000;
`endif

   typedef struct {
      logic [15:0] q;
      logic        ovf;
      logic        dbz;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && io.done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_done: done with no request outstanding, q=0x%0h (cycle %0d)", io.q, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("q", 32'(io.q), 32'(e.q));
            check("flags_ovf_dbz", {30'd0, io.overflow, io.div_by_zero}, {30'd0, e.ovf, e.dbz});
            check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
         end
      end
   end

   task automatic push_exp(input logic [15:0] eq, input logic eo, input logic ed);
      exp_t e;
      e.q = eq; e.ovf = eo; e.dbz = ed;
      e.lat = ed ? 2 : 34;
      e.start_cyc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int max_cyc);
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(posedge clk); #1;
         seen = io.done;
      end
      check("done_seen", {31'd0, seen}, 32'd1);
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic run(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic eo, input logic ed);
      io.start    = 1'b1;
      io.dividend = a;
      io.divisor  = b;
      push_exp(eq, eo, ed);
      @(posedge clk); #1;
      io.start = 1'b0;
      check("busy_after_start", {31'd0, io.busy}, 32'd1);
      wait_done(40);
      @(posedge clk); #1;
      check("busy_idle", {31'd0, io.busy}, 32'd0);
      check("q_held", 32'(io.q), 32'(eq));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      io.start    = 1'b0;
      io.dividend = '0;
      io.divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", 32'(io.q), 32'h0);
      check("rst_busy_done", {30'd0, io.busy, io.done}, 32'h0);
      check("rst_flags", {30'd0, io.overflow, io.div_by_zero}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      run(16'h0030, 16'h0010, 16'h00C3, 1'b0, 1'b0);  //  6.0 / 2.0
      run(16'hFFD0, 16'h0010, 16'hFF43, 1'b0, 1'b0);  // -6.0 / 2.0
      run(16'h0030, 16'hFFF0, 16'hFF43, 1'b0, 1'b0);  //  6.0 / -2.0
      run(16'hFFD0, 16'hFFF0, 16'h00C3, 1'b0, 1'b0);  // -6.0 / -2.0
      run(16'h0019, 16'h0009, 16'h00C3, 1'b0, 1'b0);  //  1.5 / 0.5
      run(16'h0008, 16'h0018, 16'h0013, 1'b0, 1'b0);  //  1 / 3 -> 0.25
      run(16'h0011, 16'h0010, 16'h0023, 1'b0, 1'b0);  //  1.0(S=1) / 2.0 -> 0.5
      run(16'h0030, 16'h0012, 16'h0303, 1'b0, 1'b0);  //  6.0 / 0.5(S=2) -> 12.0
      run(16'hFFF8, 16'h0080, 16'h0003, 1'b0, 1'b0);  // -1 / 16 -> negative zero
      run(16'hF000, 16'h0008, 16'h8003, 1'b0, 1'b0);  // -512 / 1 -> exactly -4096
      run(16'h1000, 16'h0008, SAT_P,    1'b1, 1'b0);  //  512 / 1 -> +4096 overflows
      run(16'h7FF8, 16'h0008, SAT_P,    1'b1, 1'b0);  //  4095 / 1
      run(16'h8000, 16'h0008, SAT_N,    1'b1, 1'b0);  // -4096 / 1
      run(16'h0030, 16'h0005, 16'h0000, 1'b0, 1'b1);  //  divide by zero (S2=5)
      run(16'h0030, 16'h0010, 16'h00C3, 1'b0, 1'b0);  //  flags clear again

      // Start pulsed while busy is ignored and the latched operands are kept.
      io.start = 1'b1; io.dividend = 16'h0030; io.divisor = 16'h0010;
      push_exp(16'h00C3, 1'b0, 1'b0);
      @(posedge clk); #1;
      io.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      io.start = 1'b1; io.dividend = 16'h0008; io.divisor = 16'h0018;
      @(posedge clk); #1;
      io.start = 1'b0;
      wait_done(40);

      // Start held through the done cycle is taken only in the following IDLE cycle.
      io.start = 1'b1; io.dividend = 16'h0008; io.divisor = 16'h0018;
      @(posedge clk); #1;
      push_exp(16'h0013, 1'b0, 1'b0);
      @(posedge clk); #1;
      io.start = 1'b0;
      wait_done(40);
      repeat (40) @(posedge clk);
      #1;

      // Reset in ITER cycle 10 aborts the operation at once.
      io.start = 1'b1; io.dividend = 16'h0030; io.divisor = 16'h0010;
      @(posedge clk); #1;
      io.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("busy_mid_iter", {31'd0, io.busy}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("abort_q", 32'(io.q), 32'h0);
      check("abort_busy_done", {30'd0, io.busy, io.done}, 32'h0);
      check("abort_flags", {30'd0, io.overflow, io.div_by_zero}, 32'h0);
      #4;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("no_done_after_abort_q", 32'(io.q), 32'h0);
      run(16'h0019, 16'h0009, 16'h00C3, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("pending_expectations", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
